ysyx_22050133_ifu: RTL

Instruction fetch unit for the RV64 pipeline. It owns the program counter and issues in-order fetch requests to instruction memory over a valid/ready channel. Returned instruction words are buffered in a small FIFO and presented to the decode stage, paired with their PC, over a valid/ready channel. A redirect from the execute stage (branch, jump or trap target) flushes the buffer, discards in-flight responses, and restarts fetch at the new PC.

---
 rtl/ysyx_22050133_ifu_pkg.sv | 16 +
 rtl/ysyx_22050133_ifu_fifo.sv | 65 ++++++
 rtl/ysyx_22050133_ifu.sv | 122 ++++++++++++
 3 files changed

// File: rtl/ysyx_22050133_ifu_pkg.sv
// Shared constants and types for the ysyx_22050133 instruction fetch unit.
package ysyx_22050133_ifu_pkg;

    localparam logic [63:0] ysyx_22050133_RESET_PC  = 64'h8000_0000;
    localparam int          ysyx_22050133_IFU_DEPTH = 2;

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_DRAIN = 1'b1
    } ifu_state_e;

    function automatic logic [63:0] align_pc(input logic [63:0] pc);
        return pc & ~64'h3;
    endfunction

endpackage

// File: rtl/ysyx_22050133_ifu_fifo.sv
// Synchronous FIFO with flush, wrapping pointers and an occupancy count.
module ysyx_22050133_ifu_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 96
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_wdata,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_rdata,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_CNT  = CW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic w_empty;
    logic w_do_push;
    logic w_do_pop;

    assign w_empty   = (r_count == '0);
    assign w_do_pop  = i_pop && !w_empty;
    assign w_do_push = i_push && ((r_count != FULL_CNT) || w_do_pop);

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PW'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + ONE_CNT;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - ONE_CNT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Empty reads as zero so stale entries never leak onto the outputs.
    assign o_rdata = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/ysyx_22050133_ifu.sv
// Instruction fetch unit: PC ownership, credit-limited fetch, buffered delivery and redirect flush.
module ysyx_22050133_ifu
    import ysyx_22050133_ifu_pkg::*;
#(
    parameter logic [63:0] RESET_PC = ysyx_22050133_RESET_PC,
    parameter int          DEPTH    = ysyx_22050133_IFU_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [63:0] inst_pc
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] ONE_CNT = CW'(1);

    logic [63:0]   r_fetch_pc;
    logic [CW-1:0] r_out_cnt;
    logic [CW-1:0] r_disc_cnt;
    ifu_state_e    r_state;

    logic [CW-1:0] w_fifo_cnt;
    logic [CW-1:0] w_pcq_cnt;
    logic [CW:0]   w_credit_used;
    logic          w_req_fire;
    logic          w_resp_keep;
    logic          w_pcq_pop;
    logic          w_fifo_pop;
    logic [CW-1:0] w_out_next;
    logic [CW-1:0] w_disc_next;
    logic [63:0]   w_pcq_head;
    logic [95:0]   w_fifo_head;

    assign w_credit_used  = {1'b0, r_out_cnt} + {1'b0, w_fifo_cnt};
    assign imem_req_valid = !rst && (r_state == ST_FETCH) && (w_credit_used < DEPTH_W)
                            && !redirect_valid;
    assign imem_req_addr  = r_fetch_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    // A response is kept only when nothing is pending discard and no flush is happening.
    assign w_resp_keep = imem_resp_valid && (r_disc_cnt == '0) && !redirect_valid;
    assign w_pcq_pop   = w_resp_keep && (w_pcq_cnt != '0);
    assign w_fifo_pop  = inst_valid && inst_ready && !redirect_valid;

    assign w_out_next = r_out_cnt + CW'(w_req_fire) - CW'(imem_resp_valid);

    // Discards are a subset of out_cnt, so on a redirect the surviving
    // outstanding count is exactly the number of stale responses.
    always_comb begin
        w_disc_next = r_disc_cnt;
        if (redirect_valid) begin
            w_disc_next = w_out_next;
        end else if (imem_resp_valid && (r_disc_cnt != '0)) begin
            w_disc_next = r_disc_cnt - ONE_CNT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_out_cnt  <= '0;
            r_disc_cnt <= '0;
            r_state    <= ST_FETCH;
        end else begin
            r_out_cnt  <= w_out_next;
            r_disc_cnt <= w_disc_next;
            if (redirect_valid) begin
                r_fetch_pc <= align_pc(redirect_pc);
            end else if (w_req_fire) begin
                r_fetch_pc <= r_fetch_pc + 64'd4;
            end
            case (r_state)
                ST_FETCH: r_state <= (w_disc_next != '0) ? ST_DRAIN : ST_FETCH;
                ST_DRAIN: r_state <= (w_disc_next != '0) ? ST_DRAIN : ST_FETCH;
                default:  r_state <= ST_FETCH;
            endcase
        end
    end

    ysyx_22050133_ifu_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (64)
    ) u_pc_queue (
        .clk     (clk),
        .rst     (rst),
        .i_flush (redirect_valid),
        .i_push  (w_req_fire),
        .i_wdata (r_fetch_pc),
        .i_pop   (w_pcq_pop),
        .o_rdata (w_pcq_head),
        .o_count (w_pcq_cnt)
    );

    ysyx_22050133_ifu_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (96)
    ) u_inst_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (redirect_valid),
        .i_push  (w_resp_keep),
        .i_wdata ({w_pcq_head, imem_resp_data}),
        .i_pop   (w_fifo_pop),
        .o_rdata (w_fifo_head),
        .o_count (w_fifo_cnt)
    );

    assign inst_valid = !rst && (w_fifo_cnt != '0);
    assign inst       = w_fifo_head[31:0];
    assign inst_pc    = w_fifo_head[95:32];

endmodule
